// File: rtl/unit_input_dispatch_pkg.sv
// unit_input_dispatch_pkg
//   Shared constants for the unit input bus: bus width, entry-point field
//   width, unit packet type codes, the dispatcher state encoding and the
//   msb() helper used to size counters.
package unit_input_dispatch_pkg;

    localparam int UNIT_INPUT_WIDTH = 8;
    localparam int ENTRY_PT_MSB     = 4;

    // Unit packet type codes, carried in header bits [PKT_TYPE_MSB:0]
    localparam int PKT_TYPE_DATA     = 0;
    localparam int PKT_TYPE_ENTRY_PT = 1;
    localparam int PKT_TYPE_MSB      = 2;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DISCARD,
        CFG_HDR,
        CFG_END
    } disp_state_t;

    // Index of the highest set bit (0 for v == 0)
    function automatic int msb(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if (v[i]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/unit_input_dispatch_rr_select.sv
// unit_input_dispatch_rr_select
//   Combinational round-robin search: first set bit of ready, starting at
//   ptr+1 and wrapping, so the unit at ptr is the last candidate.
//   ready  : per-unit ready mask
//   ptr    : index of the previously selected unit
//   onehot : selected unit as a one-hot vector
//   idx    : selected unit index
//   found  : at least one unit ready
module unit_input_dispatch_rr_select #(
    parameter int N_UNITS = 8,
    parameter int PW      = 3
) (
    input  logic [N_UNITS-1:0] ready,
    input  logic [PW-1:0]      ptr,
    output logic [N_UNITS-1:0] onehot,
    output logic [PW-1:0]      idx,
    output logic               found
);

    logic [PW-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        for (int i = 1; i <= N_UNITS; i++) begin
            j = PW'((int'(ptr) + i) % N_UNITS);
            if (!found && ready[j]) begin
                found     = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/unit_input_dispatch.sv
// unit_input_dispatch
//   Takes 32-bit framed packets from the arbiter and serializes them onto the
//   narrow unit input bus. Data packets go to one ready unit chosen
//   round-robin; entry-point config packets are broadcast to every unit.
//   CLK          : clock, same as the units' WR_CLK
//   rst          : synchronous active-high reset
//   in_data/in_type/in_last/in_valid : arbiter word stream
//   in_rd_en     : word consumed this cycle (combinational)
//   out/out_ctrl : shared unit bus data and framing flag (registered)
//   out_wr_en    : per-unit write strobe (registered)
//   unit_ready   : unit can take a new data packet
//   unit_afull   : unit asks for writes to pause
//   err_overflow : sticky, a packet overran the unit input buffer
module unit_input_dispatch
    import unit_input_dispatch_pkg::*;
#(
    parameter int N_UNITS       = 8,
    parameter int INPUT_WIDTH   = UNIT_INPUT_WIDTH,
    parameter int RATIO         = 32 / INPUT_WIDTH,
    parameter int INPUT_N_WORDS = 128
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic [31:0]            in_data,
    input  logic                   in_type,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_rd_en,
    output logic [INPUT_WIDTH-1:0] out,
    output logic                   out_ctrl,
    output logic [N_UNITS-1:0]     out_wr_en,
    input  logic [N_UNITS-1:0]     unit_ready,
    input  logic [N_UNITS-1:0]     unit_afull,
    output logic                   err_overflow
);

    localparam int CW = msb(INPUT_N_WORDS - 1) + 1;
    localparam int KW = msb(RATIO - 1) + 1;
    localparam int PW = msb(N_UNITS - 1) + 1;
    localparam int TW = PKT_TYPE_MSB + 1;

    disp_state_t               state;
    logic [PW-1:0]             rr, sel;
    logic [N_UNITS-1:0]        sel_1h;
    logic [CW-1:0]             cnt;
    logic [KW-1:0]             k;
    logic                      cfg_err;

    logic [N_UNITS-1:0]        rs_onehot;
    logic [PW-1:0]             rs_idx;
    logic                      rs_found;

    logic [RATIO-1:0][INPUT_WIDTH-1:0] subw;
    logic                      stall, last_sub, final_sub, ovf;

    unit_input_dispatch_rr_select #(.N_UNITS(N_UNITS), .PW(PW)) u_rr (
        .ready  (unit_ready),
        .ptr    (rr),
        .onehot (rs_onehot),
        .idx    (rs_idx),
        .found  (rs_found)
    );

    // LSB-first split of the arbiter word
    assign subw      = in_data[RATIO*INPUT_WIDTH-1:0];
    assign stall     = ~in_valid | unit_afull[sel];
    assign last_sub  = (k == KW'(RATIO - 1));
    assign final_sub = last_sub & in_last;
    // The buffer's last slot is reached before the packet ends: that subword
    // closes the packet early and the rest is thrown away.
    assign ovf       = (cnt == CW'(INPUT_N_WORDS - 1)) & ~final_sub;

    always_comb begin
        in_rd_en = 1'b0;
        case (state)
            DATA:    in_rd_en = ~stall & (last_sub | ovf);
            DISCARD: in_rd_en = in_valid;
            CFG_HDR: in_rd_en = in_valid;
            default: in_rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state        <= IDLE;
            rr           <= PW'(N_UNITS - 1);
            sel          <= '0;
            sel_1h       <= '0;
            cnt          <= '0;
            k            <= '0;
            cfg_err      <= 1'b0;
            out          <= '0;
            out_ctrl     <= 1'b0;
            out_wr_en    <= '0;
            err_overflow <= 1'b0;
        end else begin
            out_wr_en <= '0;
            case (state)
                IDLE: begin
                    out_ctrl <= 1'b0;
                    if (in_valid && in_type == 1'(PKT_TYPE_ENTRY_PT)) begin
                        // config waits for every unit; nothing behind it can pass
                        if (&unit_ready) state <= CFG_HDR;
                    end else if (in_valid && in_type == 1'(PKT_TYPE_DATA) && rs_found) begin
                        sel    <= rs_idx;
                        sel_1h <= rs_onehot;
                        rr     <= rs_idx;
                        state  <= HDR;
                    end
                end
                HDR: begin
                    out       <= INPUT_WIDTH'(PKT_TYPE_DATA);
                    out_ctrl  <= 1'b1;
                    out_wr_en <= sel_1h;
                    cnt       <= '0;
                    k         <= '0;
                    state     <= DATA;
                end
                DATA: begin
                    if (!stall) begin
                        out       <= subw[k];
                        out_wr_en <= sel_1h;
                        cnt       <= cnt + 1'b1;
                        k         <= last_sub ? '0 : k + 1'b1;
                        if (ovf) begin
                            out_ctrl     <= 1'b1;
                            err_overflow <= 1'b1;
                            state        <= in_last ? IDLE : DISCARD;
                        end else begin
                            out_ctrl <= final_sub;
                            if (final_sub) state <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    out_ctrl <= 1'b0;
                    if (in_valid && in_last) state <= IDLE;
                end
                CFG_HDR: begin
                    // idle units never write their buffer, so afull is ignored
                    if (in_valid) begin
                        out       <= INPUT_WIDTH'({in_data[ENTRY_PT_MSB:0], TW'(PKT_TYPE_ENTRY_PT)});
                        out_ctrl  <= 1'b1;
                        out_wr_en <= '1;
                        cfg_err   <= ~in_last;
                        if (!in_last) err_overflow <= 1'b1;
                        state     <= CFG_END;
                    end
                end
                CFG_END: begin
                    out       <= '0;
                    out_ctrl  <= 1'b1;
                    out_wr_en <= '1;
                    state     <= cfg_err ? DISCARD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unit_input_dispatch.sv
// tb_unit_input_dispatch
//   Random and directed stimulus; every bus write is checked against a
//   queue of expected writes built from the packet format rules.
module tb_unit_input_dispatch;
    import unit_input_dispatch_pkg::*;

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_type, in_last, in_valid;
    logic        in_rd_en;
    logic [7:0]  out;
    logic        out_ctrl;
    logic [7:0]  out_wr_en, unit_ready, unit_afull;
    logic        err_overflow;

    always #5 CLK = ~CLK;

    unit_input_dispatch dut (
        .CLK          (CLK),
        .rst          (rst),
        .in_data      (in_data),
        .in_type      (in_type),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_rd_en     (in_rd_en),
        .out          (out),
        .out_ctrl     (out_ctrl),
        .out_wr_en    (out_wr_en),
        .unit_ready   (unit_ready),
        .unit_afull   (unit_afull),
        .err_overflow (err_overflow)
    );

    int          n_tests = 0, n_fail = 0, n_wr = 0, n_rd = 0;
    logic [7:0]  en_mask = '0, busy, afull_force = '0, af_rand = '0;
    bit          rand_af = 0, sb_en = 0;
    logic [16:0] exp_q[$];          // {wr_en, out, ctrl}
    logic [7:0]  sb_last_out = '0;
    logic [31:0] pkt[$];
    int          m_rr = 7;
    bit          m_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Unit model: a ctrl write toggles between idle and receiving.
    always @(posedge CLK)
        if (rst) busy <= '0;
        else if (out_ctrl) busy <= busy ^ out_wr_en;
    assign unit_ready = en_mask & ~busy;

    always @(negedge CLK) af_rand = 8'($urandom) & 8'($urandom);
    assign unit_afull = rand_af ? af_rand : afull_force;

    always @(posedge CLK) if (!rst && in_rd_en) n_rd++;

    // Scoreboard
    always @(negedge CLK) begin
        logic [16:0] e;
        if (!rst && out_wr_en != 0) begin
            n_wr++;
            if (sb_en) begin
                if (exp_q.size() == 0) chk("extra_wr", 32'(out_wr_en), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("bus_wr", {15'd0, out_wr_en, out, out_ctrl}, {15'd0, e});
                    sb_last_out = e[8:1];
                end
            end
        end
    end

    function automatic int pick(input int rr, input logic [7:0] m);
        for (int i = 1; i <= 8; i++)
            if (m[(rr + i) % 8]) return (rr + i) % 8;
        return 0;
    endfunction

    // Call at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [31:0] d, input logic t, input logic l);
        int   waited;
        logic took;
        in_data = d; in_type = t; in_last = l; in_valid = 1'b1;
        waited = 0; took = 1'b0;
        while (!took) begin
            #2 took = in_rd_en;
            @(negedge CLK);
            waited++;
            if (!took && waited > 3000) begin
                chk("rd_timeout", 32'd0, 32'd1);
                took = 1'b1;
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(negedge CLK); t++; end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic fill(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back($urandom);
    endtask

    task automatic run_data(input bit gaps);
        int          sel, s, nw;
        logic [7:0]  oh, b;
        logic [31:0] w;
        bit          fin, done;
        nw  = pkt.size();
        sel = pick(m_rr, en_mask);
        m_rr = sel;
        oh  = 8'(1 << sel);
        exp_q.push_back({oh, 8'h00, 1'b1});
        s = 0; done = 0;
        for (int i = 0; i < nw; i++)
            for (int j = 0; j < 4; j++)
                if (!done) begin
                    w   = pkt[i];
                    b   = w[8*j +: 8];
                    fin = (i == nw - 1) && (j == 3);
                    if (s == 127 && !fin) begin
                        exp_q.push_back({oh, b, 1'b1});
                        m_err = 1; done = 1;
                    end else begin
                        exp_q.push_back({oh, b, fin});
                        s++;
                    end
                end
        for (int i = 0; i < nw; i++) begin
            send_word(pkt[i], 1'b0, 1'(i == nw - 1));
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge CLK);
            end
        end
        in_valid = 1'b0;
        wait_drain();
        chk("err_ovf", 32'(err_overflow), 32'(m_err));
    endtask

    task automatic run_cfg(input logic [31:0] d);
        exp_q.push_back({8'hFF, d[4:0], 3'b001, 1'b1});
        exp_q.push_back({8'hFF, 8'h00, 1'b1});
        send_word(d, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        int w0, r0, t;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_type = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_wr", 32'(out_wr_en), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        chk("rst_rr", 32'(dut.rr), 32'd7);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0; sb_en = 1;
        @(negedge CLK);

        // all ready, nine one-word packets: units 0..7 then 0
        en_mask = 8'hFF;
        for (int i = 0; i < 9; i++) begin fill(1); run_data(0); end

        // single ready unit, two-word packet
        en_mask = 8'h04;
        pkt = '{32'h44332211, 32'h88776655};
        r0 = n_rd;
        run_data(0);
        chk("t1_rd", 32'(n_rd - r0), 32'd2);

        // afull held for five cycles mid-packet
        fill(4);
        w0 = n_wr;
        fork
            run_data(0);
            begin
                t = 0;
                while (n_wr - w0 < 3 && t < 200) begin @(negedge CLK); t++; end
                afull_force = 8'hFF;
                repeat (5) begin
                    @(negedge CLK);
                    chk("af_wr", 32'(out_wr_en), 32'd0);
                    chk("af_out", 32'(out), 32'(sb_last_out));
                end
                afull_force = 8'h00;
            end
        join

        // config broadcast, then config held for a non-ready unit
        en_mask = 8'hFF;
        run_cfg(32'h0000_0005);
        chk("cfg_state", 32'(dut.state), 32'(IDLE));
        en_mask = 8'hFE;
        w0 = n_wr; r0 = n_rd;
        fork
            run_cfg(32'h0000_0013);
            begin
                repeat (10) @(negedge CLK);
                chk("cfg_hold_wr", 32'(n_wr - w0), 32'd0);
                chk("cfg_hold_rd", 32'(n_rd - r0), 32'd0);
                en_mask = 8'hFF;
            end
        join

        // 40-word packet overruns the 128-subword buffer
        fill(40);
        r0 = n_rd;
        run_data(0);
        chk("ovf_rd", 32'(n_rd - r0), 32'd40);
        fill(1);
        run_data(0);

        // reset in the middle of a data packet
        sb_en = 0;
        in_data = 32'hDEADBEEF; in_type = 1'b0; in_last = 1'b0; in_valid = 1'b1;
        repeat (8) @(negedge CLK);
        chk("pre_rst_state", 32'(dut.state), 32'(DATA));
        rst = 1'b1;
        @(negedge CLK);
        chk("mid_rst_wr", 32'(out_wr_en), 32'd0);
        chk("mid_rst_ctrl", 32'(out_ctrl), 32'd0);
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_err", 32'(err_overflow), 32'd0);
        chk("mid_rst_rr", 32'(dut.rr), 32'd7);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        in_valid = 1'b0;
        @(negedge CLK);
        rst = 1'b0;
        exp_q.delete(); m_rr = 7; m_err = 0; sb_en = 1;
        @(negedge CLK);

        // randomized mix with random afull and input gaps
        rand_af = 1;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                en_mask = 8'hFF;
                run_cfg($urandom);
            end else begin
                en_mask = 8'($urandom);
                if (en_mask == 0) en_mask = 8'h01;
                fill(($urandom_range(0, 9) == 0) ? 34 : $urandom_range(1, 6));
                run_data(1);
            end
        end
        rand_af = 0;
        repeat (5) @(negedge CLK);
        chk("q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
